// File: rtl/twiddle_gen.sv
// FFT twiddle-factor generator: quarter-wave cosine table with quadrant folding,
// random-access requests plus a strided index sequencer, 2-stage pipeline.
module twiddle_gen #(
    parameter int LOG2N = 5,
    parameter int DW    = 32,
    parameter int FRAC  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOG2N-1:0]     in_addr,
    input  logic                 seq_start,
    input  logic [LOG2N-1:0]     seq_stride,
    input  logic [LOG2N:0]       seq_count,
    output logic                 seq_busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic [LOG2N-1:0]     out_idx,
    output logic                 out_last
);
    localparam int N  = 1 << LOG2N;
    localparam int QN = N / 4;
    localparam int AW = LOG2N - 1;
    localparam int RW = LOG2N - 2;
    localparam logic [LOG2N:0] CNT_ONE = 1;
    localparam real PI = 3.14159265358979323846;

    // Elaboration-time cos via Taylor series; angle stays within [0, pi/2].
    function automatic logic signed [DW-1:0] cos_q(input int i);
        real x;
        real term;
        real sum;
        x    = 2.0 * PI * real'(i) / real'(N);
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < 20; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return DW'($rtoi(sum * (2.0 ** FRAC) + 0.5));
    endfunction

    function automatic logic signed [DW-1:0] cond_neg(input logic signed [DW-1:0] v,
                                                      input logic neg);
        return neg ? -v : v;
    endfunction

    logic signed [DW-1:0] cos_tbl [0:QN];
    for (genvar g = 0; g <= QN; g++) begin : g_tbl
        assign cos_tbl[g] = cos_q(g);
    end

    typedef enum logic {IDLE, SEQ} state_t;
    state_t state, state_nxt;

    logic             en;
    logic [LOG2N-1:0] seq_k;
    logic [LOG2N-1:0] stride_r;
    logic [LOG2N:0]   seq_left;
    logic             seq_launch;

    logic             issue_vld;
    logic [LOG2N-1:0] issue_k;
    logic             issue_last;

    assign en         = !out_valid || out_ready;
    assign seq_busy   = (state == SEQ);
    assign in_ready   = (state == IDLE) && !seq_start && en && !rst;
    // A launch pulse is taken even while the output is stalled so it is never lost.
    assign seq_launch = (state == IDLE) && seq_start && (seq_count != '0);

    always_comb begin
        state_nxt  = state;
        issue_vld  = 1'b0;
        issue_k    = in_addr;
        issue_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (seq_launch) begin
                    state_nxt = SEQ;
                end else if (in_valid && in_ready) begin
                    issue_vld = 1'b1;
                end
            end
            SEQ: begin
                issue_k    = seq_k;
                issue_last = (seq_left == CNT_ONE);
                if (en) begin
                    issue_vld = 1'b1;
                    if (seq_left == CNT_ONE) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (seq_launch) begin
            seq_k    <= '0;
            stride_r <= seq_stride;
            seq_left <= seq_count;
        end else if (state == SEQ && en) begin
            seq_k    <= seq_k + stride_r;
            seq_left <= seq_left - CNT_ONE;
        end
    end

    // Quadrant fold: pick table address and sign for each component.
    logic [1:0]    quad;
    logic [AW-1:0] r_ext;
    logic [AW-1:0] r_cmp;
    logic [AW-1:0] re_addr, im_addr;
    logic          re_neg, im_neg;

    always_comb begin
        quad    = issue_k[LOG2N-1:LOG2N-2];
        r_ext   = {1'b0, issue_k[RW-1:0]};
        r_cmp   = AW'(QN) - r_ext;
        re_addr = r_ext;
        im_addr = r_cmp;
        re_neg  = 1'b0;
        im_neg  = 1'b1;
        unique case (quad)
            2'd0: begin re_addr = r_ext; re_neg = 1'b0; im_addr = r_cmp; im_neg = 1'b1; end
            2'd1: begin re_addr = r_cmp; re_neg = 1'b1; im_addr = r_ext; im_neg = 1'b1; end
            2'd2: begin re_addr = r_ext; re_neg = 1'b1; im_addr = r_cmp; im_neg = 1'b0; end
            default: begin re_addr = r_cmp; re_neg = 1'b0; im_addr = r_ext; im_neg = 1'b0; end
        endcase
    end

    // ---- stage 1: folded index and signs ----
    logic             vld_p1;
    logic             last_p1;
    logic [LOG2N-1:0] k_p1;
    logic [AW-1:0]    re_addr_p1, im_addr_p1;
    logic             re_neg_p1, im_neg_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (en) begin
            vld_p1  <= issue_vld;
            last_p1 <= issue_last;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            k_p1       <= issue_k;
            re_addr_p1 <= re_addr;
            im_addr_p1 <= im_addr;
            re_neg_p1  <= re_neg;
            im_neg_p1  <= im_neg;
        end
    end

    // ---- stage 2: table read, negate, output registers ----
    logic vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_last <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
            out_idx  <= '0;
        end else if (en) begin
            vld_p2   <= vld_p1;
            out_last <= vld_p1 && last_p1;
            out_re   <= cond_neg(cos_tbl[re_addr_p1], re_neg_p1);
            out_im   <= cond_neg(cos_tbl[im_addr_p1], im_neg_p1);
            out_idx  <= k_p1;
        end
    end

    assign out_valid = vld_p2;

endmodule

// File: tb/tb_twiddle_gen.sv
// Randomised and directed bench for twiddle_gen; results are scored against a
// floating-point cos/-sin model and a queue of expected indices.
module tb_twiddle_gen;
    localparam int LOG2N = 5;
    localparam int DW    = 32;
    localparam int FRAC  = 16;
    localparam int N     = 1 << LOG2N;
    localparam real PI   = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [LOG2N-1:0]     in_addr;
    logic                 seq_start;
    logic [LOG2N-1:0]     seq_stride;
    logic [LOG2N:0]       seq_count;
    logic                 seq_busy;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [LOG2N-1:0]     out_idx;
    logic                 out_last;

    always #5 clk = ~clk;

    twiddle_gen #(.LOG2N(LOG2N), .DW(DW), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .seq_start(seq_start), .seq_stride(seq_stride), .seq_count(seq_count),
        .seq_busy(seq_busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
    );

    typedef struct {
        int     k;
        bit     last;
        longint re;
        longint im;
        int     acc;
        bit     lat;
    } item_t;

    item_t  sbq[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cycle    = 0;
    bit     chk_rdy  = 1'b0;
    bit     lat_mode = 1'b0;
    bit     dir_on   = 1'b0;
    longint dir_re, dir_im;

    bit     have_prev = 1'b0;
    longint prev_re, prev_im, prev_idx, prev_last;

    function automatic longint rnd_q(input real v);
        if (v >= 0.0) return longint'($rtoi($floor(v + 0.5)));
        return -longint'($rtoi($floor(-v + 0.5)));
    endfunction

    function automatic real ang(input int k);
        return 2.0 * PI * real'(k) / real'(N);
    endfunction

    function automatic item_t mk(input int k, input bit last, input int acc, input bit lat);
        item_t it;
        it.k    = k;
        it.last = last;
        it.re   = rnd_q($cos(ang(k)) * (2.0 ** FRAC));
        it.im   = rnd_q(-$sin(ang(k)) * (2.0 ** FRAC));
        it.acc  = acc;
        it.lat  = lat;
        return it;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic sample();
        item_t e;
        item_t it;
        real   dr, di;
        cycle++;
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            sbq.delete();
            have_prev = 1'b0;
            return;
        end
        if (have_prev) begin
            check("hold_vld", out_valid, 1);
            check("hold_re", out_re, prev_re);
            check("hold_im", out_im, prev_im);
            check("hold_idx", out_idx, prev_idx);
            check("hold_last", out_last, prev_last);
        end
        if (chk_rdy)
            check("in_ready", in_ready, !seq_start && (!out_valid || out_ready));
        if (sbq.size() == 0) begin
            check("spurious_vld", out_valid, 0);
        end else if (out_valid && out_ready) begin
            e = sbq.pop_front();
            check("idx", out_idx, e.k);
            check("re", out_re, e.re);
            check("im", out_im, e.im);
            check("last", out_last, e.last);
            dr = real'(out_re) - $cos(ang(int'(out_idx))) * (2.0 ** FRAC);
            di = real'(out_im) + $sin(ang(int'(out_idx))) * (2.0 ** FRAC);
            check("tol_re", (dr <= 1.0 && dr >= -1.0), 1);
            check("tol_im", (di <= 1.0 && di >= -1.0), 1);
            if (e.lat) check("latency", cycle - e.acc, 2);
        end
        have_prev = out_valid && !out_ready;
        prev_re   = out_re;
        prev_im   = out_im;
        prev_idx  = out_idx;
        prev_last = out_last;
        if (in_valid && in_ready) begin
            it = mk(int'(in_addr), 1'b0, cycle, lat_mode);
            if (dir_on) begin
                it.re = dir_re;
                it.im = dir_im;
            end
            sbq.push_back(it);
        end
    endtask

    task automatic step();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        seq_start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (sbq.size() == 0) break;
            step();
        end
        check("drain_left", sbq.size(), 0);
        sbq.delete();
        step();
        check("busy_idle", seq_busy, 0);
        chk_rdy = 1'b1;
    endtask

    task automatic launch(input int stride, input int count, input bit also_valid);
        chk_rdy    = 1'b1;
        seq_start  = 1'b1;
        seq_stride = LOG2N'(stride);
        seq_count  = (LOG2N + 1)'(count);
        in_valid   = also_valid;
        in_addr    = LOG2N'($urandom);
        for (int i = 0; i < count; i++)
            sbq.push_back(mk((i * stride) % N, i == count - 1, -1, 1'b0));
        step();
        seq_start = 1'b0;
        in_valid  = 1'b0;
        check("busy_launch", seq_busy, count != 0);
        chk_rdy = (count == 0);
    endtask

    int     dk  [5] = '{0, 1, 8, 17, 24};
    longint dre [5] = '{64'h10000, 64'hFB15, 0, -64'd64277, 0};
    longint dim [5] = '{0, -64'd12785, -64'd65536, 64'h31F1, 64'h10000};

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_addr    = '0;
        seq_start  = 1'b0;
        seq_stride = '0;
        seq_count  = '0;
        out_ready  = 1'b1;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_busy", seq_busy, 0);
        rst     = 1'b0;
        chk_rdy = 1'b1;

        // directed random-access values with latency
        lat_mode = 1'b1;
        dir_on   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_addr  = LOG2N'(dk[i]);
            dir_re   = dre[i];
            dir_im   = dim[i];
            step();
        end
        dir_on   = 1'b0;
        drain(20);
        lat_mode = 1'b0;

        // exhaustive sweep
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_addr  = LOG2N'(k);
            step();
        end
        drain(20);

        // stride 3, count 12, back-to-back
        launch(3, 12, 1'b0);
        for (int i = 0; i < 14; i++) step();
        check("seq_b2b_left", sbq.size(), 0);
        drain(10);

        // stall mid-sequence
        launch(5, 10, 1'b0);
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        drain(40);

        // stride 0 with full count
        launch(0, N, 1'b0);
        drain(60);

        // seq_start beats in_valid; zero-count launch ignored
        launch(9, 6, 1'b1);
        drain(30);
        launch(4, 0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("zero_cnt_busy", seq_busy, 0);
        drain(5);

        // reset mid-sequence
        launch(7, 20, 1'b0);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_vld", out_valid, 0);
        chk_rdy = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("rst_mid_busy", seq_busy, 0);

        // random access with random back-pressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = $urandom_range(0, 1);
            in_addr   = LOG2N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(20);

        // random sequences with interfering requests and back-pressure
        for (int s = 0; s < 8; s++) begin
            int st, ct;
            st = $urandom_range(0, N - 1);
            ct = $urandom_range(0, N);
            launch(st, ct, $urandom_range(0, 1));
            for (int i = 0; i < ct + 8; i++) begin
                in_valid  = $urandom_range(0, 1);
                in_addr   = LOG2N'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
                step();
            end
            drain(200);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
